// File: rtl/cache_axi_mem_responder_if.sv
// Refill/writeback handshake between the cache (master) and its memory responder (slave).
interface cache_axi_mem_responder_if;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;

   modport master (
      output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
   );
   modport slave (
      input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
   );
endinterface

// File: rtl/cache_axi_mem_responder.sv
// Word-organised test memory answering cache line refills/writebacks, one transaction at a time.
// Optional CACHE_MEM_RAND_GAP_EN inserts LFSR-driven idle cycles between read beats.
module cache_axi_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LATENCY = 2,
   parameter int WR_LATENCY = 1
) (
   input logic clk,
   input logic rst,
   cache_axi_mem_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BEAT, WR_WAIT} state_t;

   state_t                state;
   logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] r_idx, w_idx, acc_idx;
   logic                  r_line, w_line, acc_line, rd_acc, wr_acc, commit;
   logic [1:0]            beat, nxt_beat;
   logic [3:0]            lat_cnt, w_strb;
   logic [127:0]          w_data;

   // Upper address bits alias by design; byte-offset bits carry no meaning.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.rd_addr[31:ADDR_WIDTH+2], bus.rd_addr[1:0],
                               bus.wr_addr[31:ADDR_WIDTH+2], bus.wr_addr[1:0]};

   assign bus.wr_rdy = (state == IDLE);
   assign bus.rd_rdy = (state == IDLE) & ~bus.wr_req;
   assign rd_acc     = bus.rd_req & bus.rd_rdy;
   assign wr_acc     = bus.wr_req & bus.wr_rdy;
   assign acc_line   = (bus.rd_type == 3'b100);
   assign acc_idx    = acc_line ? {bus.rd_addr[ADDR_WIDTH+1:4], 2'b00} : bus.rd_addr[ADDR_WIDTH+1:2];
   assign nxt_beat   = beat + 2'd1;
   assign commit     = (state == WR_WAIT) && (lat_cnt == 4'd0);

`ifdef CACHE_MEM_RAND_GAP_EN
   logic [7:0] lfsr;
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 8'h5A;
      else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.ret_valid <= 1'b0;
         bus.ret_last  <= 1'b0;
         bus.ret_data  <= 32'd0;
         beat          <= 2'd0;
         lat_cnt       <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               bus.ret_valid <= 1'b0;
               bus.ret_last  <= 1'b0;
               if (wr_acc) begin
                  w_line  <= (bus.wr_type == 3'b100);
                  w_idx   <= bus.wr_addr[ADDR_WIDTH+1:2];
                  w_strb  <= bus.wr_wstrb;
                  w_data  <= bus.wr_data;
                  lat_cnt <= 4'(WR_LATENCY - 1);
                  state   <= WR_WAIT;
               end else if (rd_acc) begin
                  r_idx  <= acc_idx;
                  r_line <= acc_line;
                  beat   <= 2'd0;
                  if (RD_LATENCY == 1) begin
                     bus.ret_valid <= 1'b1;
                     bus.ret_data  <= mem[acc_idx];
                     bus.ret_last  <= ~acc_line;
                     state         <= RD_BEAT;
                  end else begin
                     lat_cnt <= 4'(RD_LATENCY - 2);
                     state   <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (lat_cnt == 4'd0) begin
                  bus.ret_valid <= 1'b1;
                  bus.ret_data  <= mem[r_idx];
                  bus.ret_last  <= ~r_line;
                  state         <= RD_BEAT;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            RD_BEAT: begin
               if (bus.ret_valid && bus.ret_last) begin
                  bus.ret_valid <= 1'b0;
                  bus.ret_last  <= 1'b0;
                  beat          <= 2'd0;
                  state         <= IDLE;
               end
`ifdef CACHE_MEM_RAND_GAP_EN
               // A gap is only taken right after a beat, so at most one idle cycle in a row.
               else if (bus.ret_valid && lfsr[0]) begin
                  bus.ret_valid <= 1'b0;
               end
`endif
               else begin
                  bus.ret_valid <= 1'b1;
                  bus.ret_data  <= mem[{r_idx[ADDR_WIDTH-1:2], nxt_beat}];
                  bus.ret_last  <= (nxt_beat == 2'd3);
                  beat          <= nxt_beat;
               end
            end
            WR_WAIT: begin
               if (lat_cnt == 4'd0) state <= IDLE;
               else                 lat_cnt <= lat_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Contents survive reset; a write still pending when reset hits is dropped.
   always_ff @(posedge clk) begin
      if (!rst && commit) begin
         if (w_line) begin
            for (int i = 0; i < 4; i++)
               mem[{w_idx[ADDR_WIDTH-1:2], 2'(i)}] <= w_data[32*i +: 32];
         end else begin
            for (int b = 0; b < 4; b++)
               if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_cache_axi_mem_responder.sv
// Directed table-driven bench for cache_axi_mem_responder plus multi-cycle corner sequences.
module tb_cache_axi_mem_responder;
   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;
`ifdef CACHE_MEM_RAND_GAP_EN
   localparam int GAP_MAX = 1;
`else
   localparam int GAP_MAX = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   cache_axi_mem_responder_if bus();
   cache_axi_mem_responder #(.ADDR_WIDTH(10), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT))
      dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      bit               is_wr;
      logic [2:0]       typ;
      logic [31:0]      addr;
      logic [3:0]       strb;
      logic [127:0]     wdata;
      int               nb;
      logic [3:0][31:0] exp;
   } vec_t;

   vec_t tbl[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Starts in the cycle after read accept and gathers the return beats.
   task automatic collect(input string nm, input int nb, input logic [3:0][31:0] exp);
      int got = 0, c = 1, gap = 0;
      while (got < nb && c < 40) begin
         if (bus.ret_valid) begin
            if (got == 0) check({nm, " latency"}, c, RD_LAT);
            else          check({nm, " gap"}, (gap > GAP_MAX) ? gap : 0, 0);
            check({nm, " data"}, bus.ret_data, exp[got]);
            check({nm, " last"}, {31'd0, bus.ret_last}, {31'd0, got == nb - 1});
            got++;
            gap = 0;
         end else if (got > 0) gap++;
         tick();
         c++;
      end
      check({nm, " beats"}, got, nb);
      check({nm, " idle after"}, {31'd0, bus.ret_valid}, 0);
   endtask

   task automatic do_read(input string nm, input logic [2:0] typ, input logic [31:0] addr,
                          input int nb, input logic [3:0][31:0] exp);
      int k = 0;
      bus.rd_req = 1'b1; bus.rd_type = typ; bus.rd_addr = addr;
      while (!bus.rd_rdy && k < 40) begin tick(); k++; end
      check({nm, " rd_rdy"}, {31'd0, bus.rd_rdy}, 1);
      tick();
      bus.rd_req = 1'b0;
      collect(nm, nb, exp);
   endtask

   task automatic do_write(input string nm, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [127:0] data);
      int k = 0;
      bus.wr_req = 1'b1; bus.wr_type = typ; bus.wr_addr = addr;
      bus.wr_wstrb = strb; bus.wr_data = data;
      while (!bus.wr_rdy && k < 40) begin tick(); k++; end
      tick();
      bus.wr_req = 1'b0;
      k = 0;
      while (!bus.wr_rdy && k < 40) begin tick(); k++; end
      check({nm, " wr busy cycles"}, k, WR_LAT);
   endtask

   initial begin
      logic [3:0][31:0] e;
      int got, k, extra;

      bus.rd_req = 0; bus.rd_type = 0; bus.rd_addr = 0;
      bus.wr_req = 0; bus.wr_type = 0; bus.wr_addr = 0; bus.wr_wstrb = 0; bus.wr_data = 0;

      tbl[0]  = '{1, 3'b100, 32'h1230, 4'h0, 128'h44444444_33333333_22222222_11111111, 0, '0};
      tbl[1]  = '{0, 3'b100, 32'h1230, 4'h0, '0, 4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}};
      tbl[2]  = '{1, 3'b010, 32'h1234, 4'b0011, 128'h0000ABCD, 0, '0};
      tbl[3]  = '{0, 3'b010, 32'h1234, 4'h0, '0, 1, {96'd0, 32'h2222ABCD}};
      tbl[4]  = '{1, 3'b010, 32'h1000, 4'hF, 128'hDEADBEEF, 0, '0};
      tbl[5]  = '{0, 3'b000, 32'h0000, 4'h0, '0, 1, {96'd0, 32'hDEADBEEF}};
      tbl[6]  = '{1, 3'b010, 32'h1238, 4'h0, 128'hFFFFFFFF, 0, '0};
      tbl[7]  = '{0, 3'b100, 32'h123C, 4'h0, '0, 4, {32'h44444444, 32'h33333333, 32'h2222ABCD, 32'h11111111}};
      tbl[8]  = '{0, 3'b010, 32'h3230, 4'h0, '0, 1, {96'd0, 32'h11111111}};
      tbl[9]  = '{1, 3'b010, 32'h1230, 4'b1100, 128'hCAFE0000, 0, '0};
      tbl[10] = '{0, 3'b011, 32'h1230, 4'h0, '0, 1, {96'd0, 32'hCAFE1111}};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset ret_valid", {31'd0, bus.ret_valid}, 0);
      check("reset ret_last", {31'd0, bus.ret_last}, 0);
      check("reset ret_data", bus.ret_data, 0);
      check("reset rd_rdy", {31'd0, bus.rd_rdy}, 1);
      check("reset wr_rdy", {31'd0, bus.wr_rdy}, 1);

      for (int i = 0; i < 11; i++) begin
         if (tbl[i].is_wr) do_write($sformatf("vec%0d", i), tbl[i].typ, tbl[i].addr, tbl[i].strb, tbl[i].wdata);
         else              do_read($sformatf("vec%0d", i), tbl[i].typ, tbl[i].addr, tbl[i].nb, tbl[i].exp);
      end

      // Simultaneous read and write: write goes first, read waits for commit.
      bus.rd_req = 1; bus.rd_type = 3'b100; bus.rd_addr = 32'h2000;
      bus.wr_req = 1; bus.wr_type = 3'b100; bus.wr_addr = 32'h2000;
      bus.wr_wstrb = 4'h0; bus.wr_data = {4{32'h55555555}};
      #1;
      check("simul rd_rdy", {31'd0, bus.rd_rdy}, 0);
      check("simul wr_rdy", {31'd0, bus.wr_rdy}, 1);
      tick();
      bus.wr_req = 0;
      check("simul busy wr_rdy", {31'd0, bus.wr_rdy}, 0);
      check("simul busy rd_rdy", {31'd0, bus.rd_rdy}, 0);
      k = 0;
      while (!bus.rd_rdy && k < 40) begin tick(); k++; end
      check("simul read wait", k, WR_LAT);
      tick();
      bus.rd_req = 0;
      collect("simul", 4, {4{32'h55555555}});

      // Reset right after beat 1 of a line read.
      bus.rd_req = 1; bus.rd_type = 3'b100; bus.rd_addr = 32'h1230;
      k = 0;
      while (!bus.rd_rdy && k < 40) begin tick(); k++; end
      tick();
      bus.rd_req = 0;
      got = 0; k = 0;
      while (got < 2 && k < 40) begin
         if (bus.ret_valid) got++;
         if (got < 2) tick();
         k++;
      end
      check("rstmid beat1 seen", got, 2);
      check("rstmid beat1 data", bus.ret_data, 32'h2222ABCD);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid ret_valid", {31'd0, bus.ret_valid}, 0);
      check("rstmid rd_rdy", {31'd0, bus.rd_rdy}, 1);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.ret_valid) extra++;
         tick();
      end
      check("rstmid no more beats", extra, 0);
      e = {32'h44444444, 32'h33333333, 32'h2222ABCD, 32'hCAFE1111};
      do_read("after rst", 3'b100, 32'h1230, 4, e);
      do_read("alias line", 3'b100, 32'h0000, 4, {4{32'h55555555}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cache_axi_mem_responder.md
Name: cache_axi_mem_responder

Overview:
Memory-side responder for the cache's refill/writeback interface (rd_req/rd_rdy/ret_*, wr_req/wr_rdy/wr_*).
- Services line refills and line writebacks from an internal word-organised memory, with configurable latency.
- Used as the standalone-cache test memory, and as the interface model that a later AXI bridge replaces.
- Handles one transaction at a time, so write-then-read ordering is always coherent.

Parameters:
- ADDR_WIDTH, 10, word-index bits of internal memory (2^ADDR_WIDTH 32-bit words).
- RD_LATENCY, 2, cycles from read accept to first ret_valid beat; legal range 1..15.
- WR_LATENCY, 1, busy cycles after write accept before commit; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rd_req  in  1  read request.
- rd_type  in  3  3'b100 = 4-word line; any other value = single word.
- rd_addr  in  32  byte address.
- rd_rdy  out  1  responder can accept a read this cycle.
- ret_valid  out  1  return beat valid.
- ret_last  out  1  final beat of the read.
- ret_data  out  32  return beat data.
- wr_req  in  1  write request.
- wr_type  in  3  3'b100 = line; other values = single word.
- wr_addr  in  32  byte address.
- wr_wstrb  in  4  byte enables for word writes.
- wr_data  in  128  line data; word 0 in [31:0].
- wr_rdy  out  1  responder can accept a write this cycle.

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Reset values: state IDLE, ret_valid=0, ret_last=0, ret_data=0, beat/latency counters=0. rd_rdy=1 and wr_rdy=1 in the first cycle after reset. Memory contents are not reset.
- Single FSM, states IDLE, RD_WAIT, RD_BEAT, WR_WAIT.
- wr_rdy = (state==IDLE).
- rd_rdy = (state==IDLE) & ~wr_req. Write wins on a simultaneous request, and the read is accepted only after the write commits.
- Read accept: rd_req & rd_rdy at edge E.
  - Captures type and address. Word index = addr[ADDR_WIDTH+1:2], modulo memory size; upper address bits are ignored (aliasing).
  - Line reads clear index bits [1:0] and return words 0,1,2,3 in order.
  - Word reads return one beat.
- Read timing: after accept the FSM enters RD_WAIT. The first ret_valid cycle is RD_LATENCY cycles after the accept cycle. Remaining beats follow back-to-back, one per cycle.
  - ret_last=1 only with the final beat: beat 3 for a line, beat 0 for a word.
  - After the last beat: ret_valid=0 and state=IDLE.
  - No backpressure: the receiver must take every beat.
- ret_data is registered and holds its last value when ret_valid=0.
- Write accept: wr_req & wr_rdy captures type, address, wstrb and data. The FSM enters WR_WAIT for WR_LATENCY cycles, and memory updates at the edge ending the last WR_WAIT cycle. wr_rdy returns high the following cycle.
  - Line write: all 4 words written; wstrb ignored; base = index with bits [1:0] cleared.
  - Word write: only the bytes enabled by wr_wstrb are written, from wr_data[31:0]. wstrb=0 is a legal no-op.
- Requests arriving outside IDLE are not accepted. Requesters must hold them until accepted.
- Reset mid-transaction: the transaction is aborted and any pending write is discarded. ret_valid=0 from the next cycle; IDLE afterwards.

Optional Feature:
- Macro CACHE_MEM_RAND_GAP_EN.
- When defined: an 8-bit LFSR (seed 8'h5A at reset; taps 7,5,4,3) advances every cycle. Before each non-first read beat, if lfsr[0]==1, one idle cycle with ret_valid=0 is inserted. This stresses the receiver's beat counter. Beat order, data and ret_last are unchanged.
- When undefined: beats are strictly back-to-back and there is no LFSR logic.

Test Plan:
1. Line write then read. Line write addr 0x0000_1230, data 128'h44444444_33333333_22222222_11111111 → wr_rdy low for 1 cycle. Then line read 0x1230 → beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, first beat 2 cycles after accept, ret_last only on the 4th.
2. Strobed word write. Word write 0x1234, wstrb 4'b0011, data 0x0000ABCD; then word read 0x1234 → single beat 0x2222ABCD with ret_last=1.
3. Simultaneous requests. rd_req and wr_req asserted in the same IDLE cycle, write = line 0x2000 of all-5s → rd_rdy=0 that cycle and the write is accepted. The read is accepted after commit and returns 0x55555555 ×4.
4. Address aliasing. ADDR_WIDTH=10, word write 0x0000_1000 data 0xDEADBEEF → word read 0x0000_0000 returns 0xDEADBEEF.
5. Reset mid-read. Assert rst for one cycle after beat 1 of a line read → ret_valid=0 from the next cycle, no further beats, rd_rdy=1 after reset. A new read returns correct data.
6. CACHE_MEM_RAND_GAP_EN defined. Line read → exactly 4 ret_valid beats in order, gaps of at most 1 cycle, ret_last on the 4th beat.
